// File: rtl/i2c_scl_gen_stretch_if.sv
// Bus bundle between the byte engine and the SCL clock generator.
// The generator uses the slave modport; the engine/pad side uses master.
interface i2c_scl_gen_stretch_if #(
  parameter int DIV_W = 16,
  parameter int TO_W  = 20
);
  logic             enable;
  logic [DIV_W-1:0] div_q;
  logic [TO_W-1:0]  to_limit;
  logic             scl_in;
  logic             scl_oe;
  logic             data_clk;
  logic [1:0]       phase;
  logic             scl_high;
  logic             data_strobe;
  logic             sample_strobe;
  logic             busy;
  logic             stretching;
  logic             timeout;

  modport master (
    output enable, div_q, to_limit, scl_in,
    input  scl_oe, data_clk, phase, scl_high,
    input  data_strobe, sample_strobe,
    input  busy, stretching, timeout
  );

  modport slave (
    input  enable, div_q, to_limit, scl_in,
    output scl_oe, data_clk, phase, scl_high,
    output data_strobe, sample_strobe,
    output busy, stretching, timeout
  );
endinterface

// File: rtl/i2c_scl_gen_stretch.sv
// Four-quarter I2C SCL generator with slave clock-stretch
// detection on the synchronised pad level and stretch timeout.
module i2c_scl_gen_stretch #(
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TO_W        = 20,
  parameter int STRETCH_EN  = 1
) (
  input  logic clk,
  input  logic rst,
  i2c_scl_gen_stretch_if.slave bus
);

  typedef enum logic [2:0] {
    Q0   = 3'b000,
    Q1   = 3'b001,
    Q2   = 3'b010,
    Q3   = 3'b011,
    IDLE = 3'b100
  } state_e;

  localparam logic [DIV_W-1:0] DQ_MIN =
    DIV_W'(SYNC_STAGES + 2);

  state_e                 state_q, state_d;
  logic [DIV_W-1:0]       cnt_q, cnt_d;
  logic [DIV_W-1:0]       dq_q, dq_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   oe_q, oe_d;
  logic                   dclk_q, dclk_d;

  logic [DIV_W-1:0] dq_in;
  logic             scl_s;
  logic             last;
  logic             hold;
  logic             to_hit;

  assign dq_in  = (bus.div_q < DQ_MIN) ? DQ_MIN
                                       : bus.div_q;
  assign scl_s  = sync_q[SYNC_STAGES-1];
  assign last   = (cnt_q == dq_q - DIV_W'(1));
  assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.scl_in};

  // Guard skips the cycles where the synchroniser still
  // shows our own low drive from Q1.
  assign hold = (STRETCH_EN != 0)
             && (state_q == Q2)
             && (cnt_q >= DIV_W'(SYNC_STAGES))
             && !scl_s;

  assign to_hit = hold
               && (bus.to_limit != '0)
               && (to_cnt_q == bus.to_limit - TO_W'(1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + DIV_W'(1);
    dq_d     = dq_q;
    to_cnt_d = hold ? to_cnt_q + TO_W'(1) : '0;
    if (to_hit) begin
      state_d  = IDLE;
      cnt_d    = '0;
      to_cnt_d = '0;
    end else if (hold) begin
      cnt_d = cnt_q;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (bus.enable) begin
            state_d = Q0;
            dq_d    = dq_in;
          end
        end
        Q0, Q1, Q2: begin
          if (last) begin
            state_d = state_e'(state_q + 3'd1);
            cnt_d   = '0;
          end
        end
        Q3: begin
          if (last) begin
            cnt_d = '0;
            if (bus.enable) begin
              state_d = Q0;
              dq_d    = dq_in;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    oe_d   = (state_d == Q0) || (state_d == Q1);
    dclk_d = (state_d == Q1) || (state_d == Q2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dq_q     <= DQ_MIN;
      to_cnt_q <= '0;
      sync_q   <= '1;
      oe_q     <= 1'b0;
      dclk_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dq_q     <= dq_d;
      to_cnt_q <= to_cnt_d;
      sync_q   <= sync_d;
      oe_q     <= oe_d;
      dclk_q   <= dclk_d;
    end
  end

  assign bus.scl_oe        = oe_q;
  assign bus.data_clk      = dclk_q;
  assign bus.phase         = state_q[1:0];
  assign bus.scl_high      = ~state_q[2] & state_q[1];
  assign bus.busy          = ~state_q[2];
  assign bus.data_strobe   = (state_q == Q1)
                          && (cnt_q == '0);
  assign bus.sample_strobe = (state_q == Q2)
                          && last && !hold;
  assign bus.stretching    = hold;
  assign bus.timeout       = to_hit;

endmodule

// File: tb/tb_i2c_scl_gen_stretch.sv
// Directed bench for i2c_scl_gen_stretch: vector table plus
// stretch, timeout and async-reset sequences.
module tb_i2c_scl_gen_stretch;

  localparam int DIV_W = 16;
  localparam int TO_W  = 20;

  logic clk = 1'b0;
  logic rst;
  logic hold;

  i2c_scl_gen_stretch_if #(
    .DIV_W(DIV_W), .TO_W(TO_W)
  ) bus ();

  // Wired-AND pad: our pull-low or a stretching slave.
  assign bus.scl_in = ~bus.scl_oe & ~hold;

  i2c_scl_gen_stretch #(
    .DIV_W(DIV_W), .SYNC_STAGES(2),
    .TO_W(TO_W), .STRETCH_EN(1)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  wire [9:0] got = {bus.scl_oe, bus.data_clk,
                    bus.phase, bus.scl_high,
                    bus.data_strobe,
                    bus.sample_strobe, bus.busy,
                    bus.stretching, bus.timeout};

  typedef struct {
    logic             en;
    logic [DIV_W-1:0] dq;
    logic [9:0]       exp;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(string nm,
                     logic [31:0] g,
                     logic [31:0] e);
    n_vec++;
    if (g !== e) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               nm, g, e);
    end
  endtask

  function automatic logic [9:0] wave(int q, int c);
    int ph;
    logic [1:0] p;
    ph = c / q;
    p  = 2'(ph);
    return {ph < 2, ph == 1 || ph == 2, p, ph >= 2,
            c == q, c == 3 * q - 1,
            1'b1, 1'b0, 1'b0};
  endfunction

  task automatic add_period(int q, int dq0, int dq1,
                            int chg, int enoff);
    for (int c = 0; c < 4 * q; c++) begin
      vec_t v;
      v.en  = (c < enoff);
      v.dq  = DIV_W'(c < chg ? dq0 : dq1);
      v.exp = wave(q, c);
      vq.push_back(v);
    end
  endtask

  task automatic add_idle(int n, int dq);
    for (int c = 0; c < n; c++) begin
      vec_t v;
      v.en  = 1'b0;
      v.dq  = DIV_W'(dq);
      v.exp = '0;
      vq.push_back(v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start(int dq, int tl);
    bus.div_q    = DIV_W'(dq);
    bus.to_limit = TO_W'(tl);
    bus.enable   = 1'b1;
    step();
    chk("start_q0",
        32'({bus.phase, bus.busy, bus.scl_oe}),
        32'({2'b00, 1'b1, 1'b1}));
  endtask

  initial begin
    int k, nstr, nss, nds, busyc, bad, first;
    int nto, tok, n;

    rst          = 1'b1;
    hold         = 1'b0;
    bus.enable   = 1'b0;
    bus.div_q    = DIV_W'(4);
    bus.to_limit = '0;

    add_period(4, 4, 4, 99, 99);
    add_period(4, 4, 4, 99, 99);
    add_period(4, 1, 1, 99, 99);
    add_period(5, 5, 6, 12, 99);
    add_period(6, 6, 6, 99, 8);
    add_idle(3, 6);

    repeat (2) @(negedge clk);
    chk("reset", 32'(got), 32'(0));
    rst = 1'b0;

    foreach (vq[i]) begin
      bus.enable = vq[i].en;
      bus.div_q  = vq[i].dq;
      step();
      chk($sformatf("vec%0d", i),
          32'(got), 32'(vq[i].exp));
    end

    // Slave stretch of 10 pad cycles in Q2, div_q=8.
    start(8, 0);
    k = 0; nstr = 0; nss = 0; nds = 0;
    busyc = 0; bad = 0; first = -1;
    while (bus.busy && k < 200) begin
      busyc++;
      if (bus.stretching) begin
        nstr++;
        if (first < 0) first = k;
        if (bus.phase != 2'd2 || bus.scl_oe) bad++;
      end
      if (bus.sample_strobe) nss++;
      if (bus.data_strobe) nds++;
      hold = (k >= 18 && k < 28);
      if (bus.phase == 2'd3) bus.enable = 1'b0;
      step();
      k++;
    end
    hold = 1'b0;
    chk("str_bound", 32'(k < 200), 32'(1));
    chk("str_cycles", nstr, 10);
    chk("str_first", first, 20);
    chk("str_period", busyc, 42);
    chk("str_sample", nss, 1);
    chk("str_dstrobe", nds, 1);
    chk("str_window", bad, 0);

    // Slave stuck low, to_limit=50, enable held high.
    hold = 1'b1;
    start(4, 50);
    k = 0; nto = 0; tok = -1; nstr = 0; nss = 0;
    while (k < 62) begin
      if (bus.timeout) begin
        nto++;
        tok = k;
      end
      if (bus.stretching) nstr++;
      if (bus.sample_strobe) nss++;
      if (k == 60)
        chk("to_idle",
            32'({bus.busy, bus.scl_oe, bus.phase}),
            32'(0));
      if (k == 61) begin
        chk("to_restart",
            32'({bus.phase, bus.busy, bus.scl_oe}),
            32'({2'b00, 1'b1, 1'b1}));
        hold = 1'b0;
        bus.enable = 1'b0;
      end
      step();
      k++;
    end
    chk("to_pulses", nto, 1);
    chk("to_cycle", tok, 59);
    chk("to_str_cycles", nstr, 50);
    chk("to_no_sample", nss, 0);
    n = 0;
    while (bus.busy && n < 100) begin
      step();
      n++;
    end
    chk("to_drain", 32'(bus.busy), 32'(0));

    // Asynchronous reset in the middle of Q0.
    start(4, 0);
    step();
    #2 rst = 1'b1;
    #1 chk("rst_async", 32'(got), 32'(0));
    bus.enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("rst_idle", 32'(got), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
